// File: rtl/tiny_cpu_pkg.sv
// Shared types and constants for the tiny CPU front end.
package tiny_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_LO = 2'd1,
        REQ_HI = 2'd2,
        DONE   = 2'd3
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/program_counter.sv
// Program counter with a deferred (pending) load slot and wrapping +1/+2 incrementers.
module program_counter #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic                  pend_set_i,
    input  logic                  inc2_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus1_o,
    output logic                  pending_o
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [ADDR_WIDTH-1:0] pc_plus2;

    assign pc_plus1_o = pc_q + ADDR_WIDTH'(1);
    assign pc_plus2   = pc_q + ADDR_WIDTH'(2);

    // A direct load beats a pending load, which beats the normal +2 advance.
    always_comb begin
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        pend_flag_d = pend_flag_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc2_i) begin
            pc_d = pend_flag_q ? pend_addr_q : pc_plus2;
        end
        if (inc2_i) begin
            pend_flag_d = 1'b0;
        end else if (pend_set_i) begin
            pend_flag_d = 1'b1;
            pend_addr_d = load_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pc_q        <= RESET_PC;
            pend_addr_q <= '0;
            pend_flag_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            pend_flag_q <= pend_flag_d;
        end
    end

    assign pc_o      = pc_q;
    assign pending_o = pend_flag_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: reads a 16-bit little-endian instruction as two bus bytes and
// strobes it into the instruction register unless a jump squashed the fetch.
module instruction_fetch
    import tiny_cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  fetch_req_in,
    input  logic                  pc_load_en_in,
    input  logic [ADDR_WIDTH-1:0] pc_load_data_in,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  busy_out,
    output logic                  mem_req_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic                  mem_ack_in,
    input  logic [7:0]            mem_rdata_in,
    output logic                  ir_write_en_out,
    output logic [15:0]           ir_data_out
);

    fetch_state_t          state_q, state_d;
    logic [7:0]            lo_q, lo_d;
    logic [7:0]            hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] pc, pc_plus1;
    logic                  pending;
    logic                  in_bus;

    assign in_bus = (state_q == REQ_LO) || (state_q == REQ_HI);

    // Loads during the bus phase are deferred so the transfer always completes.
    program_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk_i       (clk_in),
        .srst_i      (reset_in),
        .load_i      (pc_load_en_in && !in_bus),
        .load_addr_i (pc_load_data_in),
        .pend_set_i  (pc_load_en_in && in_bus),
        .inc2_i      (state_q == DONE),
        .pc_o        (pc),
        .pc_plus1_o  (pc_plus1),
        .pending_o   (pending)
    );

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            IDLE:   if (fetch_req_in) state_d = REQ_LO;
            REQ_LO: if (mem_ack_in) begin
                        lo_d    = mem_rdata_in;
                        state_d = REQ_HI;
                    end
            REQ_HI: if (mem_ack_in) begin
                        hi_d    = mem_rdata_in;
                        state_d = DONE;
                    end
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            lo_q    <= NOP_INSTR[7:0];
            hi_q    <= NOP_INSTR[15:8];
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        mem_addr_out = '0;
        if (state_q == REQ_LO) mem_addr_out = pc;
        if (state_q == REQ_HI) mem_addr_out = pc_plus1;
    end

    assign mem_req_out     = in_bus;
    assign busy_out        = (state_q != IDLE);
    assign ir_write_en_out = (state_q == DONE) && !pending;
    assign ir_data_out     = {hi_q, lo_q};
    assign pc_out          = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized transaction-level check of instruction_fetch against a byte-memory model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        fetch_req_in;
    logic        pc_load_en_in;
    logic [15:0] pc_load_data_in;
    logic [15:0] pc_out;
    logic        busy_out;
    logic        mem_req_out;
    logic [15:0] mem_addr_out;
    logic        mem_ack_in;
    logic [7:0]  mem_rdata_in;
    logic        ir_write_en_out;
    logic [15:0] ir_data_out;

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk_in          (clk),
        .reset_in        (reset_in),
        .fetch_req_in    (fetch_req_in),
        .pc_load_en_in   (pc_load_en_in),
        .pc_load_data_in (pc_load_data_in),
        .pc_out          (pc_out),
        .busy_out        (busy_out),
        .mem_req_out     (mem_req_out),
        .mem_addr_out    (mem_addr_out),
        .mem_ack_in      (mem_ack_in),
        .mem_rdata_in    (mem_rdata_in),
        .ir_write_en_out (ir_write_en_out),
        .ir_data_out     (ir_data_out)
    );

    logic [7:0]  mem [0:65535];
    logic [15:0] model_pc;
    logic        exp_pend;
    logic [15:0] exp_pend_val;
    int          n_checks = 0;
    int          n_errors = 0;

    localparam logic [16:0] NONE = 17'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One byte transfer: req held for waits+1 cycles, ack on the last one.
    task automatic byte_phase(input string tag, input logic [15:0] addr, input int waits,
                              input logic [16:0] forced_ld, input int load_prob);
        for (int k = 0; k <= waits; k++) begin
            check_eq({tag, " req"}, 32'(mem_req_out), 32'(1));
            check_eq({tag, " addr"}, 32'(mem_addr_out), 32'(addr));
            check_eq({tag, " busy"}, 32'(busy_out), 32'(1));
            check_eq({tag, " strobe"}, 32'(ir_write_en_out), 32'(0));
            mem_ack_in   = (k == waits);
            mem_rdata_in = (k == waits) ? mem[addr] : 8'($urandom);
            pc_load_en_in = 1'b0;
            if (k == 0 && forced_ld[16]) begin
                pc_load_en_in   = 1'b1;
                pc_load_data_in = forced_ld[15:0];
            end else if (int'($urandom_range(99)) < load_prob) begin
                pc_load_en_in   = 1'b1;
                pc_load_data_in = 16'($urandom);
            end
            if (pc_load_en_in) begin
                exp_pend     = 1'b1;
                exp_pend_val = pc_load_data_in;
            end
            tick;
        end
        mem_ack_in    = 1'b0;
        pc_load_en_in = 1'b0;
    endtask

    task automatic do_fetch(input string tag, input logic [16:0] idle_ld, input int wlo, input int whi,
                            input logic [16:0] lo_ld, input logic [16:0] hi_ld,
                            input logic [16:0] done_ld, input int load_prob);
        logic [15:0] next_pc;
        logic [15:0] word;
        check_eq({tag, " idle req"}, 32'(mem_req_out), 32'(0));
        check_eq({tag, " idle addr"}, 32'(mem_addr_out), 32'(0));
        check_eq({tag, " idle busy"}, 32'(busy_out), 32'(0));
        check_eq({tag, " idle pc"}, 32'(pc_out), 32'(model_pc));
        fetch_req_in  = 1'b1;
        mem_ack_in    = 1'($urandom);
        pc_load_en_in = idle_ld[16];
        pc_load_data_in = idle_ld[15:0];
        if (idle_ld[16]) model_pc = idle_ld[15:0];
        tick;
        fetch_req_in  = 1'b0;
        pc_load_en_in = 1'b0;
        mem_ack_in    = 1'b0;
        exp_pend      = 1'b0;
        byte_phase({tag, " lo"}, model_pc, wlo, lo_ld, load_prob);
        byte_phase({tag, " hi"}, model_pc + 16'd1, whi, hi_ld, load_prob);
        word = {mem[model_pc + 16'd1], mem[model_pc]};
        check_eq({tag, " done busy"}, 32'(busy_out), 32'(1));
        check_eq({tag, " done req"}, 32'(mem_req_out), 32'(0));
        check_eq({tag, " done strobe"}, 32'(ir_write_en_out), 32'(!exp_pend));
        if (!exp_pend) check_eq({tag, " ir data"}, 32'(ir_data_out), 32'(word));
        mem_ack_in = 1'($urandom);
        if (done_ld[16]) begin
            pc_load_en_in   = 1'b1;
            pc_load_data_in = done_ld[15:0];
            next_pc = done_ld[15:0];
        end else if (exp_pend) begin
            next_pc = exp_pend_val;
        end else begin
            next_pc = model_pc + 16'd2;
        end
        tick;
        mem_ack_in    = 1'b0;
        pc_load_en_in = 1'b0;
        check_eq({tag, " after strobe"}, 32'(ir_write_en_out), 32'(0));
        check_eq({tag, " after busy"}, 32'(busy_out), 32'(0));
        check_eq({tag, " next pc"}, 32'(pc_out), 32'(next_pc));
        model_pc = next_pc;
        $display("fetch %s: pc_next=%04h squashed=%0d", tag, next_pc, exp_pend);
    endtask

    task automatic do_load(input string tag, input logic [15:0] val);
        pc_load_en_in   = 1'b1;
        pc_load_data_in = val;
        tick;
        pc_load_en_in = 1'b0;
        model_pc = val;
        check_eq({tag, " pc"}, 32'(pc_out), 32'(val));
        $display("load %s: pc=%04h", tag, val);
    endtask

    initial begin
        logic [16:0] ild, dld;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h34;
        mem[1] = 8'h12;
        reset_in = 1'b1;
        fetch_req_in = 1'b0;
        pc_load_en_in = 1'b0;
        pc_load_data_in = 16'h0;
        mem_ack_in = 1'b0;
        mem_rdata_in = 8'h0;
        tick;
        tick;
        reset_in = 1'b0;
        model_pc = 16'h0000;
        check_eq("reset pc", 32'(pc_out), 32'(0));
        check_eq("reset req", 32'(mem_req_out), 32'(0));
        check_eq("reset addr", 32'(mem_addr_out), 32'(0));
        check_eq("reset strobe", 32'(ir_write_en_out), 32'(0));
        check_eq("reset ir", 32'(ir_data_out), 32'(0));
        check_eq("reset busy", 32'(busy_out), 32'(0));

        do_fetch("zero_wait", NONE, 0, 0, NONE, NONE, NONE, 0);
        do_fetch("wait_3_2", NONE, 3, 2, NONE, NONE, NONE, 0);
        do_load("to_ffff", 16'hFFFF);
        do_fetch("wrap", NONE, 0, 1, NONE, NONE, NONE, 0);
        do_fetch("squash_hi", NONE, 1, 0, NONE, {1'b1, 16'h0100}, NONE, 0);
        do_fetch("two_loads", NONE, 0, 0, {1'b1, 16'h0200}, {1'b1, 16'h0300}, NONE, 0);
        do_fetch("idle_load", {1'b1, 16'h0040}, 0, 0, NONE, NONE, NONE, 0);
        do_fetch("done_load", NONE, 0, 0, NONE, NONE, {1'b1, 16'h0500}, 0);

        // Reset while the low byte is outstanding.
        fetch_req_in = 1'b1;
        tick;
        fetch_req_in = 1'b0;
        check_eq("rst_mid req before", 32'(mem_req_out), 32'(1));
        reset_in = 1'b1;
        tick;
        reset_in = 1'b0;
        model_pc = 16'h0000;
        check_eq("rst_mid req", 32'(mem_req_out), 32'(0));
        check_eq("rst_mid pc", 32'(pc_out), 32'(0));
        check_eq("rst_mid strobe", 32'(ir_write_en_out), 32'(0));
        check_eq("rst_mid busy", 32'(busy_out), 32'(0));
        $display("reset mid-fetch: pc=%04h", pc_out);

        for (int n = 0; n < 60; n++) begin
            ild = ($urandom_range(3) == 0) ? {1'b1, 16'($urandom)} : NONE;
            dld = ($urandom_range(4) == 0) ? {1'b1, 16'($urandom)} : NONE;
            if ($urandom_range(7) == 0) do_load("rand", 16'($urandom));
            do_fetch($sformatf("rand%0d", n), ild, int'($urandom_range(3)), int'($urandom_range(3)),
                     NONE, NONE, dld, 12);
            for (int g = int'($urandom_range(2)); g > 0; g--) begin
                mem_ack_in = 1'($urandom);
                tick;
                mem_ack_in = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
